sysex_patch_dump: RTL and testbench

- Read-side master of the patch parameter register bus: on request, walks all four parameter banks (osc, com, m1, m2) via adr/read/sel and captures synth_data_out.
- Serialises each bank as one MIDI SysEx message on a byte stream with valid/ready handshake, feeding the MIDI TX UART.
- Counterpart to the SysEx receive path, which writes the same registers; drives sysex_data_patch_send for the duration of a dump.

---
 rtl/sysex_patch_dump_pkg.sv | 29 ++
 rtl/sysex_tx_byte_reg.sv | 30 +++
 rtl/sysex_patch_dump.sv | 198 +++++++++++++++++++
 tb/tb_sysex_patch_dump.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysex_patch_dump_pkg.sv
// Shared constants and types for the SysEx patch dump path.
package sysex_patch_dump_pkg;

  localparam logic [7:0] SYSEX_SOX = 8'hF0;
  localparam logic [7:0] SYSEX_EOX = 8'hF7;

  typedef enum logic [1:0] {
    BANK_OSC,
    BANK_COM,
    BANK_M1,
    BANK_M2
  } bank_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DATA,
    ST_CSUM,
    ST_EOX
  } state_e;

  // Checksum byte that makes bank + data + csum == 0 mod 128.
  function automatic logic [6:0] csum_of(input logic [6:0] acc);
    return 7'(7'd0 - acc);
  endfunction

endpackage

// File: rtl/sysex_tx_byte_reg.sv
// Output byte register for the MIDI TX stream; owns the valid/ready hold rule.
module sysex_tx_byte_reg (
  input  logic       data_clk,
  input  logic       reset_data,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       accepted,
  output logic       free
);

  assign accepted = tx_valid && tx_ready;
  assign free     = !tx_valid || accepted;

  // A new byte is taken only when the slot is empty or draining this cycle.
  always_ff @(posedge data_clk) begin
    if (reset_data) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load && free) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (accepted) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sysex_patch_dump.sv
// Walks the four parameter banks and emits one SysEx message per bank.
module sysex_patch_dump
  import sysex_patch_dump_pkg::*;
#(
  parameter int         P_PER_BANK = 128,
  parameter int         ADR_WIDTH  = 7,
  parameter int         READ_LAT   = 1,
  parameter logic [7:0] MFR_ID     = 8'h7D,
  parameter logic [7:0] DEV_ID     = 8'h00
) (
  input  logic                 data_clk,
  input  logic                 reset_data,
  input  logic                 dump_req,
  output logic                 busy,
  output logic [ADR_WIDTH-1:0] adr,
  output logic                 read,
  output logic                 osc_sel,
  output logic                 com_sel,
  output logic                 m1_sel,
  output logic                 m2_sel,
  output logic                 sysex_data_patch_send,
  input  logic signed [7:0]    synth_data_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 dump_done
);

  localparam logic [ADR_WIDTH-1:0] LAST_ADR = ADR_WIDTH'(P_PER_BANK - 1);
  localparam logic [1:0]           LAST_WAIT = 2'(READ_LAT - 1);

  state_e               state_q, state_d;
  bank_e                bank_q, bank_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [1:0]           hi_q, hi_d;
  logic [1:0]           wait_q, wait_d;
  logic [7:0]           hold_q, hold_d;
  logic [6:0]           acc_q, acc_d;
  logic                 sent_q, sent_d;
  logic                 done_q, done_d;

  logic       load;
  logic [7:0] load_data;
  logic       accepted;
  logic       free;

  sysex_tx_byte_reg u_tx (
    .data_clk  (data_clk),
    .reset_data(reset_data),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .accepted  (accepted),
    .free      (free)
  );

  // State and datapath registers.
  always_ff @(posedge data_clk) begin
    if (reset_data) begin
      state_q <= ST_IDLE;
      bank_q  <= BANK_OSC;
      adr_q   <= '0;
      hi_q    <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      acc_q   <= '0;
      sent_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      adr_q   <= adr_d;
      hi_q    <= hi_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
      sent_q  <= sent_d;
      done_q  <= done_d;
    end
  end

  // Next-state, byte sequencing and checksum accumulation.
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    adr_d     = adr_q;
    hi_d      = hi_q;
    wait_d    = wait_q;
    hold_d    = hold_q;
    acc_d     = acc_q;
    sent_d    = sent_q;
    done_d    = 1'b0;
    load      = 1'b0;
    load_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d = ST_HDR;
          bank_d  = BANK_OSC;
          adr_d   = '0;
          hi_d    = '0;
        end
      end
      ST_HDR: begin
        if (free) begin
          load = 1'b1;
          hi_d = hi_q + 2'd1;
          case (hi_q)
            2'd0: begin
              load_data = SYSEX_SOX;
              acc_d     = '0;
            end
            2'd1: load_data = MFR_ID;
            2'd2: load_data = DEV_ID;
            default: begin
              load_data = {6'b0, bank_q};
              acc_d     = acc_q + {5'b0, bank_q};
              state_d   = ST_RD_ISSUE;
            end
          endcase
        end
      end
      ST_RD_ISSUE: begin
        wait_d  = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_q == LAST_WAIT) begin
          hold_d  = synth_data_out;
          state_d = ST_DATA;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_DATA: begin
        // Sign bit is dropped here rather than at capture; same bytes on the wire.
        if (!sent_q) begin
          if (free) begin
            load      = 1'b1;
            load_data = hold_q & 8'h7F;
            acc_d     = acc_q + hold_q[6:0];
            sent_d    = 1'b1;
          end
        end else if (accepted) begin
          sent_d = 1'b0;
          if (adr_q == LAST_ADR) begin
            state_d = ST_CSUM;
          end else begin
            adr_d   = adr_q + 1'b1;
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_CSUM: begin
        if (free) begin
          load      = 1'b1;
          load_data = {1'b0, csum_of(acc_q)};
          state_d   = ST_EOX;
        end
      end
      ST_EOX: begin
        if (!sent_q) begin
          if (free) begin
            load      = 1'b1;
            load_data = SYSEX_EOX;
            sent_d    = 1'b1;
          end
        end else if (accepted) begin
          sent_d = 1'b0;
          adr_d  = '0;
          hi_d   = '0;
          if (bank_q == BANK_M2) begin
            state_d = ST_IDLE;
            bank_d  = BANK_OSC;
            done_d  = 1'b1;
          end else begin
            bank_d  = bank_e'(bank_q + 2'd1);
            state_d = ST_HDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy                  = (state_q != ST_IDLE);
  assign sysex_data_patch_send = busy;
  assign read                  = (state_q == ST_RD_ISSUE);
  assign adr                   = adr_q;
  assign dump_done             = done_q;
  assign osc_sel               = busy && (bank_q == BANK_OSC);
  assign com_sel               = busy && (bank_q == BANK_COM);
  assign m1_sel                = busy && (bank_q == BANK_M1);
  assign m2_sel                = busy && (bank_q == BANK_M2);

endmodule

// File: tb/tb_sysex_patch_dump.sv
// Bench for sysex_patch_dump: two instances (read latency 1 and 3), a
// register-file bus model per instance, and a message-level reference model.
module tb_sysex_patch_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic tx_ready = 1'b1;
  logic dump_req1 = 1'b0;
  logic dump_req3 = 1'b0;

  logic       busy1, read1, osc_sel1, com_sel1, m1_sel1, m2_sel1, patch1, tx_valid1, done1;
  logic [6:0] adr1;
  logic [7:0] tx_data1;
  logic signed [7:0] synth1 = '0;
  logic       busy3, read3, osc_sel3, com_sel3, m1_sel3, m2_sel3, patch3, tx_valid3, done3;
  logic [6:0] adr3;
  logic [7:0] tx_data3;
  logic signed [7:0] synth3 = '0;

  logic [3:0] sels1, sels3;
  assign sels1 = {m2_sel1, m1_sel1, com_sel1, osc_sel1};
  assign sels3 = {m2_sel3, m1_sel3, com_sel3, osc_sel3};

  logic [7:0] regs [4][4];
  logic [7:0] q1[$];
  logic [7:0] q3[$];
  logic [7:0] exp_q[$];
  int rdc1[4];
  int rdc3[4];
  int hold_viol1 = 0, hold_viol3 = 0, sel_viol1 = 0, sel_viol3 = 0;
  int done_cnt1 = 0, done_cnt3 = 0;
  int rdy_mode = 0;
  int checks = 0, errors = 0;

  sysex_patch_dump #(.P_PER_BANK(4), .ADR_WIDTH(7), .READ_LAT(1), .MFR_ID(8'h7D), .DEV_ID(8'h00)) u1 (
    .data_clk(clk), .reset_data(rst), .dump_req(dump_req1), .busy(busy1), .adr(adr1), .read(read1),
    .osc_sel(osc_sel1), .com_sel(com_sel1), .m1_sel(m1_sel1), .m2_sel(m2_sel1),
    .sysex_data_patch_send(patch1), .synth_data_out(synth1), .tx_data(tx_data1),
    .tx_valid(tx_valid1), .tx_ready(tx_ready), .dump_done(done1));

  sysex_patch_dump #(.P_PER_BANK(4), .ADR_WIDTH(7), .READ_LAT(3), .MFR_ID(8'h7D), .DEV_ID(8'h00)) u3 (
    .data_clk(clk), .reset_data(rst), .dump_req(dump_req3), .busy(busy3), .adr(adr3), .read(read3),
    .osc_sel(osc_sel3), .com_sel(com_sel3), .m1_sel(m1_sel3), .m2_sel(m2_sel3),
    .sysex_data_patch_send(patch3), .synth_data_out(synth3), .tx_data(tx_data3),
    .tx_valid(tx_valid3), .tx_ready(tx_ready), .dump_done(done3));

  function automatic int sel_index(input logic [3:0] s);
    if (s[1]) return 1;
    if (s[2]) return 2;
    if (s[3]) return 3;
    return 0;
  endfunction

  // UART side: ready tied high or random ~30% high.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end
  end

  // Register file bus models: data valid READ_LAT cycles after the read cycle, garbage otherwise.
  initial begin
    logic [7:0] p1;
    logic [7:0] p3 [3];
    logic r1, r3;
    int b1, b3;
    logic [1:0] a1, a3;
    p1 = '0;
    for (int i = 0; i < 3; i++) p3[i] = '0;
    forever begin
      @(negedge clk);
      r1 = read1; b1 = sel_index(sels1); a1 = adr1[1:0];
      r3 = read3; b3 = sel_index(sels3); a3 = adr3[1:0];
      @(posedge clk);
      #1;
      p1 = r1 ? regs[b1][a1] : 8'($urandom);
      p3[2] = p3[1];
      p3[1] = p3[0];
      p3[0] = r3 ? regs[b3][a3] : 8'($urandom);
      synth1 = p1;
      synth3 = p3[2];
    end
  end

  // Observers: transferred bytes, read strobes per bank, hold-rule and select violations.
  logic       hp1 = 1'b0, hp3 = 1'b0;
  logic [7:0] hd1 = '0, hd3 = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid1 && tx_ready) q1.push_back(tx_data1);
      if (tx_valid3 && tx_ready) q3.push_back(tx_data3);
      if (read1) rdc1[sel_index(sels1)]++;
      if (read3) rdc3[sel_index(sels3)]++;
      if (hp1 && (!tx_valid1 || tx_data1 != hd1)) hold_viol1++;
      if (hp3 && (!tx_valid3 || tx_data3 != hd3)) hold_viol3++;
      if (busy1 ? !$onehot(sels1) : (sels1 != 4'b0)) sel_viol1++;
      if (busy3 ? !$onehot(sels3) : (sels3 != 4'b0)) sel_viol3++;
      if (patch1 !== busy1) sel_viol1++;
      if (patch3 !== busy3) sel_viol3++;
      if (done1) done_cnt1++;
      if (done3) done_cnt3++;
    end
    hp1 = tx_valid1 && !tx_ready && !rst;
    hd1 = tx_data1;
    hp3 = tx_valid3 && !tx_ready && !rst;
    hd3 = tx_data3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_regs();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 4; i++)
        regs[b][i] = 8'($urandom);
  endtask

  // Reference: four messages F0 7D 00 b d0..d3 csum F7, data masked to 7 bits.
  task automatic build_exp();
    int sum;
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h7D);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(b));
      sum = b;
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(regs[b][i] & 8'h7F);
        sum += regs[b][i] & 8'h7F;
      end
      exp_q.push_back(8'((128 - (sum % 128)) % 128));
      exp_q.push_back(8'hF7);
    end
  endtask

  task automatic run1();
    int n;
    dump_req1 = 1'b1;
    tick();
    dump_req1 = 1'b0;
    n = 0;
    while (busy1 && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (busy1) begin
      errors++;
      $display("FAIL dump1_timeout busy=%b required=0", busy1);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 10;
    if (busy1 !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b exp=0", busy1); end
    if (read1 !== 1'b0)      begin errors++; $display("FAIL rst_read got=%b exp=0", read1); end
    if (sels1 !== 4'b0)      begin errors++; $display("FAIL rst_sels got=%b exp=0000", sels1); end
    if (tx_valid1 !== 1'b0)  begin errors++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid1); end
    if (tx_data1 !== 8'h00)  begin errors++; $display("FAIL rst_tx_data got=%h exp=00", tx_data1); end
    if (adr1 !== 7'd0)       begin errors++; $display("FAIL rst_adr got=%0d exp=0", adr1); end
    if (done1 !== 1'b0)      begin errors++; $display("FAIL rst_done got=%b exp=0", done1); end
    if (patch1 !== 1'b0)     begin errors++; $display("FAIL rst_patch_send got=%b exp=0", patch1); end
    if (busy3 !== 1'b0)      begin errors++; $display("FAIL rst_busy3 got=%b exp=0", busy3); end
    if (tx_valid3 !== 1'b0)  begin errors++; $display("FAIL rst_tx_valid3 got=%b exp=0", tx_valid3); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_known_vector();
    logic [7:0] golden [10];
    int base, d0, sv0, got_len;
    int r0[4];
    logic [7:0] got;
    golden = '{8'hF0, 8'h7D, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h76, 8'hF7};
    rdy_mode = 0;
    randomize_regs();
    regs[0][0] = 8'h01; regs[0][1] = 8'h02; regs[0][2] = 8'h03; regs[0][3] = 8'h04;
    build_exp();
    base = q1.size(); d0 = done_cnt1; sv0 = sel_viol1;
    for (int b = 0; b < 4; b++) r0[b] = rdc1[b];
    run1();
    got_len = q1.size() - base;
    checks++;
    if (got_len != 40) begin errors++; $display("FAIL kv_length got=%0d exp=40", got_len); end
    for (int i = 0; i < 10; i++) begin
      got = (base + i < q1.size()) ? q1[base + i] : 8'hxx;
      checks++;
      if (got !== golden[i]) begin errors++; $display("FAIL kv_first_msg[%0d] got=%h exp=%h", i, got, golden[i]); end
    end
    for (int i = 10; i < 40; i++) begin
      got = (base + i < q1.size()) ? q1[base + i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL kv_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
    checks++;
    if (done_cnt1 - d0 != 1) begin errors++; $display("FAIL kv_done_pulses got=%0d exp=1", done_cnt1 - d0); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rdc1[b] - r0[b] != 4) begin errors++; $display("FAIL kv_reads_bank%0d got=%0d exp=4", b, rdc1[b] - r0[b]); end
    end
    checks++;
    if (sel_viol1 != sv0) begin errors++; $display("FAIL kv_sel_onehot got=%0d exp=0", sel_viol1 - sv0); end
  endtask

  task automatic test_negative();
    int base, sum;
    logic [7:0] got;
    rdy_mode = 0;
    randomize_regs();
    regs[0][0] = 8'hFF;
    build_exp();
    base = q1.size();
    run1();
    got = (base + 4 < q1.size()) ? q1[base + 4] : 8'hxx;
    checks++;
    if (got !== 8'h7F) begin errors++; $display("FAIL neg_data_byte got=%h exp=7f", got); end
    sum = 0;
    for (int i = 3; i <= 8; i++) sum += (base + i < q1.size()) ? int'(q1[base + i]) : 1;
    checks++;
    if (sum % 128 != 0) begin errors++; $display("FAIL neg_checksum sum_mod128 got=%0d exp=0", sum % 128); end
    for (int i = 0; i < 40; i++) begin
      got = (base + i < q1.size()) ? q1[base + i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL neg_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_random_ready();
    int base, hv0;
    logic [7:0] got;
    for (int it = 0; it < 3; it++) begin
      rdy_mode = 1;
      randomize_regs();
      build_exp();
      base = q1.size(); hv0 = hold_viol1;
      run1();
      checks++;
      if (q1.size() - base != 40) begin errors++; $display("FAIL rr_length got=%0d exp=40", q1.size() - base); end
      for (int i = 0; i < 40; i++) begin
        got = (base + i < q1.size()) ? q1[base + i] : 8'hxx;
        checks++;
        if (got !== exp_q[i]) begin errors++; $display("FAIL rr_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++;
      if (hold_viol1 != hv0) begin errors++; $display("FAIL rr_hold_rule violations=%0d exp=0", hold_viol1 - hv0); end
    end
    rdy_mode = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int base, d0, n;
    logic [7:0] got;
    rdy_mode = 0;
    tick();
    randomize_regs();
    build_exp();
    base = q1.size(); d0 = done_cnt1;
    dump_req1 = 1'b1;
    tick();
    dump_req1 = 1'b0;
    repeat (15) tick();
    dump_req1 = 1'b1;
    tick();
    dump_req1 = 1'b0;
    n = 0;
    while (!(tx_valid1 && tx_ready && tx_data1 == 8'hF7 && m2_sel1) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL b2b_final_eox_timeout waited=%0d limit=3000", n); end
    dump_req1 = 1'b1;
    tick();
    dump_req1 = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_eox_req_ignored busy=%b exp=0", busy1); end
    dump_req1 = 1'b1;
    tick();
    dump_req1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL b2b_restart busy=%b exp=1", busy1); end
    n = 0;
    while (busy1 && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (busy1) begin errors++; $display("FAIL b2b_timeout busy=%b exp=0", busy1); end
    tick();
    tick();
    checks++;
    if (q1.size() - base != 80) begin errors++; $display("FAIL b2b_length got=%0d exp=80", q1.size() - base); end
    for (int i = 0; i < 80; i++) begin
      got = (base + i < q1.size()) ? q1[base + i] : 8'hxx;
      checks++;
      if (got !== exp_q[i % 40]) begin errors++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got, exp_q[i % 40]); end
    end
    checks++;
    if (done_cnt1 - d0 != 2) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=2", done_cnt1 - d0); end
  endtask

  task automatic test_reset_mid();
    int base, d0, n;
    logic [7:0] got;
    rdy_mode = 1;
    randomize_regs();
    d0 = done_cnt1;
    dump_req1 = 1'b1;
    tick();
    dump_req1 = 1'b0;
    n = 0;
    while (!(m1_sel1 && read1) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin errors++; $display("FAIL rm_bank2_timeout waited=%0d limit=3000", n); end
    rst = 1'b1;
    tick();
    checks += 7;
    if (busy1 !== 1'b0)     begin errors++; $display("FAIL rm_busy got=%b exp=0", busy1); end
    if (tx_valid1 !== 1'b0) begin errors++; $display("FAIL rm_tx_valid got=%b exp=0", tx_valid1); end
    if (tx_data1 !== 8'h00) begin errors++; $display("FAIL rm_tx_data got=%h exp=00", tx_data1); end
    if (sels1 !== 4'b0)     begin errors++; $display("FAIL rm_sels got=%b exp=0000", sels1); end
    if (read1 !== 1'b0)     begin errors++; $display("FAIL rm_read got=%b exp=0", read1); end
    if (adr1 !== 7'd0)      begin errors++; $display("FAIL rm_adr got=%0d exp=0", adr1); end
    if (patch1 !== 1'b0)    begin errors++; $display("FAIL rm_patch_send got=%b exp=0", patch1); end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (done_cnt1 != d0) begin errors++; $display("FAIL rm_no_done_on_abort got=%0d exp=0", done_cnt1 - d0); end
    build_exp();
    base = q1.size();
    run1();
    for (int i = 0; i < 40; i++) begin
      got = (base + i < q1.size()) ? q1[base + i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL rm_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
    end
    checks++;
    if (done_cnt1 - d0 != 1) begin errors++; $display("FAIL rm_done_pulses got=%0d exp=1", done_cnt1 - d0); end
    rdy_mode = 0;
    tick();
  endtask

  task automatic test_read_lat3();
    int base, d0, sv0, hv0, n;
    int r0[4];
    logic [7:0] got;
    for (int it = 0; it < 2; it++) begin
      rdy_mode = (it == 0) ? 1 : 0;
      randomize_regs();
      build_exp();
      base = q3.size(); d0 = done_cnt3; sv0 = sel_viol3; hv0 = hold_viol3;
      for (int b = 0; b < 4; b++) r0[b] = rdc3[b];
      dump_req3 = 1'b1;
      tick();
      dump_req3 = 1'b0;
      n = 0;
      while (busy3 && n < 3000) begin
        tick();
        n++;
      end
      checks++;
      if (busy3) begin errors++; $display("FAIL lat3_timeout busy=%b exp=0", busy3); end
      tick();
      tick();
      checks++;
      if (q3.size() - base != 40) begin errors++; $display("FAIL lat3_length got=%0d exp=40", q3.size() - base); end
      for (int i = 0; i < 40; i++) begin
        got = (base + i < q3.size()) ? q3[base + i] : 8'hxx;
        checks++;
        if (got !== exp_q[i]) begin errors++; $display("FAIL lat3_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (rdc3[b] - r0[b] != 4) begin errors++; $display("FAIL lat3_reads_bank%0d got=%0d exp=4", b, rdc3[b] - r0[b]); end
      end
      checks += 3;
      if (sel_viol3 != sv0)  begin errors++; $display("FAIL lat3_sel_onehot got=%0d exp=0", sel_viol3 - sv0); end
      if (hold_viol3 != hv0) begin errors++; $display("FAIL lat3_hold_rule got=%0d exp=0", hold_viol3 - hv0); end
      if (done_cnt3 - d0 != 1) begin errors++; $display("FAIL lat3_done_pulses got=%0d exp=1", done_cnt3 - d0); end
    end
    rdy_mode = 0;
    tick();
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      rdc1[b] = 0;
      rdc3[b] = 0;
    end
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 4; i++)
        regs[b][i] = '0;
    test_reset();
    test_known_vector();
    test_negative();
    test_random_ready();
    test_back_to_back();
    test_reset_mid();
    test_read_lat3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
